// File: rtl/noise_lfsr_checker_if.sv
// Sample strobe, received noise bit and status bundle between a noise
// source (or bench) and noise_lfsr_checker.
interface noise_lfsr_checker_if #(
  parameter int ERR_COUNT_BITS = 8
);
  logic                      sample_en;
  logic                      noise_in;
  logic                      is_white_noise;
  logic                      clear_errors;
  logic                      locked;
  logic                      bit_error;
  logic                      expected_bit;
  logic [ERR_COUNT_BITS-1:0] error_count;
  logic [1:0]                state;

  modport master (
    output sample_en, noise_in, is_white_noise, clear_errors,
    input  locked, bit_error, expected_bit, error_count, state
  );

  modport slave (
    input  sample_en, noise_in, is_white_noise, clear_errors,
    output locked, bit_error, expected_bit, error_count, state
  );
endinterface

// File: rtl/noise_lfsr_checker.sv
// Receive-side PSG noise checker: rebuilds the generator LFSR from received
// bits, predicts the next bit, locks after a run of hits, drops lock on misses.
module noise_lfsr_checker #(
  parameter int LFSR_BITS      = 17,
  parameter int LFSR_TAP0      = 0,
  parameter int LFSR_TAP1      = 1,
  parameter int CONFIRM_BITS   = 8,
  parameter int LOSS_THRESHOLD = 4,
  parameter int ERR_COUNT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_lfsr,
  noise_lfsr_checker_if.slave  bus
);

  localparam int FILL_W = $clog2(LFSR_BITS + 1);
  localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(LFSR_BITS - 1);
  localparam logic [7:0]        CONFIRM_END = 8'(CONFIRM_BITS);
  localparam logic [3:0]        LOSS_END    = 4'(LOSS_THRESHOLD);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t                    state_p1;
  logic [LFSR_BITS-1:0]      hist;
  logic [FILL_W-1:0]         fill_cnt;
  logic [7:0]                confirm_cnt;
  logic [3:0]                miss_cnt;
  logic                      prev_white;
  logic                      locked_p1;
  logic                      bit_error_p1;
  logic                      expected_p1;
  logic [ERR_COUNT_BITS-1:0] err_cnt_p1;

  // h[0] is the oldest bit, so tap indices line up with the generator's
  // register bits at the moment the oldest bit was output.
  function automatic logic predict(input logic [LFSR_BITS-1:0] h, input logic white);
    predict = white ? (h[LFSR_TAP0] ^ h[LFSR_TAP1]) : h[LFSR_TAP0];
  endfunction

  function automatic logic [ERR_COUNT_BITS-1:0] sat_inc(input logic [ERR_COUNT_BITS-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  logic [LFSR_BITS-1:0] hist_next;
  logic                 pred_now;
  logic                 window_full;
  logic                 mode_change;
  logic                 zero_trap;
  logic                 mismatch;
  logic                 err_inc;

  always_comb begin
    hist_next   = {bus.noise_in, hist[LFSR_BITS-1:1]};
    pred_now    = predict(hist, bus.is_white_noise);
    window_full = (state_p1 != HUNT);
    mode_change = window_full && (bus.is_white_noise != prev_white);
    // A white-mode all-zero window is a dead LFSR state the generator never
    // produces, so zero samples there are errors even though they "match".
    zero_trap   = bus.is_white_noise && (hist == '0);
    mismatch    = (bus.noise_in != pred_now) || zero_trap;
    err_inc     = bus.sample_en && !mode_change && window_full && mismatch;
  end

  // Sample stage -> registered outputs (one cycle after sample_en)
  always_ff @(posedge clk or posedge reset_lfsr) begin
    if (reset_lfsr) begin
      state_p1     <= HUNT;
      hist         <= '0;
      fill_cnt     <= '0;
      confirm_cnt  <= '0;
      miss_cnt     <= '0;
      prev_white   <= 1'b0;
      locked_p1    <= 1'b0;
      bit_error_p1 <= 1'b0;
      expected_p1  <= 1'b0;
      err_cnt_p1   <= '0;
    end else begin
      bit_error_p1 <= 1'b0;

      if (bus.clear_errors)
        err_cnt_p1 <= '0;
      else if (err_inc)
        err_cnt_p1 <= sat_inc(err_cnt_p1);

      if (bus.sample_en) begin
        hist        <= hist_next;
        prev_white  <= bus.is_white_noise;
        expected_p1 <= predict(hist_next, bus.is_white_noise);

        if (mode_change) begin
          state_p1    <= VERIFY;
          confirm_cnt <= '0;
          miss_cnt    <= '0;
          locked_p1   <= 1'b0;
        end else begin
          unique case (state_p1)
            HUNT: begin
              fill_cnt <= fill_cnt + 1'b1;
              if (fill_cnt == FILL_LAST) begin
                state_p1    <= VERIFY;
                confirm_cnt <= '0;
              end
            end
            VERIFY: begin
              // A miss restarts confirmation; the sliding window re-hunts on its own.
              if (mismatch) begin
                bit_error_p1 <= 1'b1;
                confirm_cnt  <= '0;
              end else if (confirm_cnt + 8'd1 == CONFIRM_END) begin
                state_p1    <= LOCKED;
                locked_p1   <= 1'b1;
                miss_cnt    <= '0;
                confirm_cnt <= '0;
              end else begin
                confirm_cnt <= confirm_cnt + 8'd1;
              end
            end
            LOCKED: begin
              if (mismatch) begin
                bit_error_p1 <= 1'b1;
                if (miss_cnt + 4'd1 == LOSS_END) begin
                  state_p1    <= HUNT;
                  locked_p1   <= 1'b0;
                  fill_cnt    <= '0;
                  miss_cnt    <= '0;
                  confirm_cnt <= '0;
                end else begin
                  miss_cnt <= miss_cnt + 4'd1;
                end
              end else begin
                miss_cnt <= '0;
              end
            end
            default: begin
              state_p1  <= HUNT;
              locked_p1 <= 1'b0;
              fill_cnt  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.locked       = locked_p1;
  assign bus.bit_error    = bit_error_p1;
  assign bus.expected_bit = expected_p1;
  assign bus.error_count  = err_cnt_p1;
  assign bus.state        = state_p1;

endmodule

// File: tb/tb_noise_lfsr_checker.sv
// Directed bench for noise_lfsr_checker: white/periodic lock, loss, mode
// change, saturation, zero trap and asynchronous reset.
module tb_noise_lfsr_checker;

  logic clk;
  logic reset_lfsr;

  noise_lfsr_checker_if #(.ERR_COUNT_BITS(8)) bus ();

  noise_lfsr_checker #(
    .LFSR_BITS(17), .LFSR_TAP0(0), .LFSR_TAP1(1),
    .CONFIRM_BITS(8), .LOSS_THRESHOLD(4), .ERR_COUNT_BITS(8)
  ) dut (
    .clk(clk),
    .reset_lfsr(reset_lfsr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  logic [16:0] gen;   // reference PSG generator, white mode
  logic [16:0] bh;    // bits the checker has been fed, bh[0] oldest
  logic        b;
  int          k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic gen_next(output logic o);
    o   = gen[0];
    gen = {gen[0] ^ gen[1], gen[16:1]};
  endtask

  task automatic strobe(input logic v);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.noise_in  = v;
    bh = {v, bh[16:1]};
    @(negedge clk);
    bus.sample_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_lfsr = 1'b1;
    repeat (2) @(negedge clk);
    reset_lfsr = 1'b0;
    gen = 17'h10000;
    bh  = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_lfsr         = 1'b1;
    bus.sample_en      = 1'b0;
    bus.noise_in       = 1'b0;
    bus.is_white_noise = 1'b1;
    bus.clear_errors   = 1'b0;
    do_reset();

    chk("rst_state",  32'(bus.state), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_err",    32'(bus.error_count), 32'd0);
    chk("rst_biterr", 32'(bus.bit_error), 32'd0);
    chk("rst_exp",    32'(bus.expected_bit), 32'd0);

    // White lock from seed 1<<16
    for (int i = 1; i <= 25; i++) begin
      gen_next(b);
      strobe(b);
      if (i == 16) chk("hunt16_state", 32'(bus.state), 32'd0);
      if (i == 17) chk("fill17_state", 32'(bus.state), 32'd1);
      if (i == 24) chk("pre_lock", 32'(bus.locked), 32'd0);
    end
    chk("lock25", 32'(bus.locked), 32'd1);
    chk("lock25_state", 32'(bus.state), 32'd2);
    chk("lock25_err", 32'(bus.error_count), 32'd0);
    for (int i = 26; i <= 39; i++) begin
      chk("white_pred", 32'(bus.expected_bit), 32'(gen[0]));
      gen_next(b);
      strobe(b);
    end

    // Single flipped bit at sample 40
    gen_next(b);
    strobe(~b);
    chk("flip_pulse", 32'(bus.bit_error), 32'd1);
    chk("flip_err", 32'(bus.error_count), 32'd1);
    chk("flip_locked", 32'(bus.locked), 32'd1);
    @(negedge clk);
    chk("pulse_width", 32'(bus.bit_error), 32'd0);
    for (int i = 41; i <= 50; i++) begin
      gen_next(b);
      strobe(b);
      chk("post_flip_clean", 32'(bus.bit_error), 32'd0);
    end
    chk("post_flip_locked", 32'(bus.locked), 32'd1);

    // Clear on an idle cycle, then four inverted bits drop lock
    @(negedge clk);
    bus.clear_errors = 1'b1;
    @(negedge clk);
    bus.clear_errors = 1'b0;
    chk("clear_idle", 32'(bus.error_count), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      gen_next(b);
      strobe(~b);
      chk("loss_pulse", 32'(bus.bit_error), 32'd1);
      chk("loss_locked", 32'(bus.locked), (i < 4) ? 32'd1 : 32'd0);
    end
    chk("loss_state", 32'(bus.state), 32'd0);
    chk("loss_err", 32'(bus.error_count), 32'd4);
    for (int i = 1; i <= 25; i++) begin
      gen_next(b);
      strobe(b);
      if (i == 16) chk("rehunt16", 32'(bus.state), 32'd0);
      if (i == 17) chk("rehunt17", 32'(bus.state), 32'd1);
      if (i == 24) chk("relock24", 32'(bus.locked), 32'd0);
    end
    chk("relock25", 32'(bus.locked), 32'd1);

    // Switch to periodic while locked; keep feeding the periodic continuation
    bus.is_white_noise = 1'b0;
    strobe(bh[0]);
    chk("toggle_state", 32'(bus.state), 32'd1);
    chk("toggle_locked", 32'(bus.locked), 32'd0);
    chk("toggle_noerr", 32'(bus.bit_error), 32'd0);
    chk("toggle_err", 32'(bus.error_count), 32'd4);
    for (int i = 1; i <= 8; i++) begin
      strobe(bh[0]);
      if (i == 7) chk("toggle_relock7", 32'(bus.locked), 32'd0);
    end
    chk("toggle_relock8", 32'(bus.locked), 32'd1);

    // Periodic stream 1 + sixteen 0s from reset
    bus.is_white_noise = 1'b0;
    do_reset();
    chk("rst2_locked", 32'(bus.locked), 32'd0);
    k = 0;
    for (int i = 1; i <= 25; i++) begin
      strobe((k % 17) == 0);
      k++;
      if (i == 24) chk("per_pre_lock", 32'(bus.locked), 32'd0);
    end
    chk("per_lock25", 32'(bus.locked), 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("per_pred", 32'(bus.expected_bit), ((k % 17) == 0) ? 32'd1 : 32'd0);
      strobe((k % 17) == 0);
      k++;
    end

    // Asynchronous reset between edges, with a bit_error pulse pending
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.noise_in  = ((k % 17) != 0);
    @(posedge clk);
    #1;
    chk("pend_pulse", 32'(bus.bit_error), 32'd1);
    chk("pend_err", 32'(bus.error_count), 32'd1);
    #1;
    reset_lfsr    = 1'b1;
    bus.sample_en = 1'b0;
    #1;
    chk("arst_locked", 32'(bus.locked), 32'd0);
    chk("arst_pulse", 32'(bus.bit_error), 32'd0);
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_err", 32'(bus.error_count), 32'd0);
    chk("arst_exp", 32'(bus.expected_bit), 32'd0);
    @(negedge clk);
    reset_lfsr = 1'b0;

    // White all-zero window: every further zero is an error
    bus.is_white_noise = 1'b1;
    do_reset();
    for (int i = 0; i < 17; i++) strobe(1'b0);
    chk("zero_fill_state", 32'(bus.state), 32'd1);
    chk("zero_fill_err", 32'(bus.error_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0);
      chk("zero_trap_pulse", 32'(bus.bit_error), 32'd1);
    end
    chk("zero_trap_err", 32'(bus.error_count), 32'd3);
    chk("zero_trap_state", 32'(bus.state), 32'd1);

    // Saturation: 300 forced mispredictions from an error count of 3
    for (int i = 1; i <= 300; i++) begin
      strobe(~(bh[0] ^ bh[1]));
      if (i == 251) chk("sat_254", 32'(bus.error_count), 32'd254);
      if (i == 252) chk("sat_255", 32'(bus.error_count), 32'd255);
    end
    chk("sat_hold", 32'(bus.error_count), 32'd255);

    // clear_errors wins over a simultaneous mismatch
    @(negedge clk);
    bus.clear_errors = 1'b1;
    bus.sample_en    = 1'b1;
    bus.noise_in     = ~(bh[0] ^ bh[1]);
    bh = {bus.noise_in, bh[16:1]};
    @(negedge clk);
    bus.clear_errors = 1'b0;
    bus.sample_en    = 1'b0;
    chk("clear_prio", 32'(bus.error_count), 32'd0);
    chk("clear_prio_pulse", 32'(bus.bit_error), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
